ci_sampler: RTL and testbench

- Custom-instruction (CI) initiator that periodically reads the four performance counters of a CI responder (the profiling block) without CPU involvement.
- Drives the CI request side (start, ciN, valueA, valueB) and collects the done/result response.
- Buffers each returned sample, tagged with its counter index, in a small FIFO that a consumer drains with a pop handshake.
- Sits beside the CPU CI port, muxed onto the responder by the integration layer.

---
 rtl/ci_sampler_pkg.sv | 28 ++
 rtl/ci_sample_fifo.sv | 53 +++++
 rtl/ci_sampler.sv | 169 ++++++++++++++++
 tb/tb_ci_sampler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ci_sampler_pkg.sv
// Shared types and constants for the CI performance-counter sampler.
// The sample entry carries a timestamp field only when CI_SAMPLER_TIMESTAMP_EN is defined.
package ci_sampler_pkg;

  localparam int CI_INDEX_W   = 2;
  localparam int NUM_COUNTERS = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    NEXT,
    WAIT_PERIOD
  } state_t;

  typedef struct packed {
`ifdef CI_SAMPLER_TIMESTAMP_EN
    logic [31:0]           timestamp;
`endif
    logic [CI_INDEX_W-1:0] index;
    logic [31:0]           result;
  } sample_t;

  function automatic logic [31:0] index_word(input logic [CI_INDEX_W-1:0] idx);
    return {{(32-CI_INDEX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/ci_sample_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when a pop
// frees the head in the same cycle. Head output reads as zero while empty.
module ci_sample_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only and is never reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ci_sampler.sv
// CI initiator that periodically sweeps the responder's four counters into a sample FIFO.
// Define CI_SAMPLER_TIMESTAMP_EN to tag each sweep's entries with a cycle timestamp.
module ci_sampler
  import ci_sampler_pkg::*;
#(
  parameter logic [7:0] CUSTOM_ID  = 8'h00,
  parameter int         FIFO_DEPTH = 8,
  parameter int         TIMEOUT    = 15
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [15:0]                 periodCycles,
  input  logic [31:0]                 controlWord,
  output logic                        ciStart,
  output logic [7:0]                  ciN,
  output logic [31:0]                 ciValueA,
  output logic [31:0]                 ciValueB,
  input  logic                        ciDone,
  input  logic [31:0]                 ciResult,
  input  logic                        popReq,
  output logic                        sampleValid,
  output logic [31:0]                 sampleData,
  output logic [1:0]                  sampleIndex,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount,
  output logic                        busy,
  output logic                        overflowErr,
  output logic                        timeoutErr
`ifdef CI_SAMPLER_TIMESTAMP_EN
  ,
  output logic [31:0]                 sampleTimestamp
`endif
);

  localparam logic [CI_INDEX_W-1:0] LAST_IDX = CI_INDEX_W'(NUM_COUNTERS - 1);

  state_t                state, state_nx;
  logic [CI_INDEX_W-1:0] idx;
  logic [7:0]            tmo_cnt;
  logic [15:0]           period_cnt;
  logic [31:0]           word_q;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  sample_t               push_entry;
  sample_t               head_entry;

  // Timer at 1 means this is the last cycle a response is still accepted.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (enable) state_nx = ISSUE;
      ISSUE:       state_nx = WAIT_DONE;
      WAIT_DONE:   if (ciDone || tmo_cnt <= 8'd1) state_nx = NEXT;
      NEXT: begin
        if (idx != LAST_IDX) state_nx = ISSUE;
        else if (enable)     state_nx = WAIT_PERIOD;
        else                 state_nx = IDLE;
      end
      WAIT_PERIOD: begin
        if (!enable)                state_nx = IDLE;
        else if (period_cnt == '0)  state_nx = ISSUE;
      end
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      tmo_cnt     <= '0;
      period_cnt  <= '0;
      word_q      <= '0;
      timeoutErr  <= 1'b0;
      overflowErr <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (enable) begin
            word_q <= controlWord;
            idx    <= '0;
          end
        end
        ISSUE:     tmo_cnt <= 8'(TIMEOUT);
        WAIT_DONE: begin
          if (!ciDone) begin
            if (tmo_cnt <= 8'd1) timeoutErr <= 1'b1;
            else                 tmo_cnt    <= tmo_cnt - 8'd1;
          end
        end
        NEXT: begin
          if (idx != LAST_IDX) idx        <= idx + CI_INDEX_W'(1);
          else if (enable)     period_cnt <= periodCycles;
        end
        WAIT_PERIOD: begin
          if (enable) begin
            if (period_cnt == '0) begin
              word_q <= controlWord;
              idx    <= '0;
            end else begin
              period_cnt <= period_cnt - 16'd1;
            end
          end
        end
        default: ;
      endcase
      if (push && fifo_full && !popReq) overflowErr <= 1'b1;
    end
  end

  assign push     = (state == WAIT_DONE) && ciDone;
  assign ciStart  = (state == ISSUE);
  assign busy     = (state == ISSUE) || (state == WAIT_DONE) || (state == NEXT);
  assign ciN      = CUSTOM_ID;
  assign ciValueA = index_word(idx);
  assign ciValueB = word_q;

`ifdef CI_SAMPLER_TIMESTAMP_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ts_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_cnt <= '0;
      ts_q    <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (state == ISSUE && idx == '0) ts_q <= cyc_cnt;
    end
  end

  always_comb begin
    push_entry           = '0;
    push_entry.timestamp = ts_q;
    push_entry.index     = idx;
    push_entry.result    = ciResult;
  end

  assign sampleTimestamp = head_entry.timestamp;
`else
  always_comb begin
    push_entry        = '0;
    push_entry.index  = idx;
    push_entry.result = ciResult;
  end
`endif

  ci_sample_fifo #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (push_entry),
    .pop   (popReq),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifoCount)
  );

  assign sampleValid = ~fifo_empty;
  assign sampleData  = head_entry.result;
  assign sampleIndex = head_entry.index;

endmodule

// File: tb/tb_ci_sampler.sv
// Randomized bench for ci_sampler: an event-level model predicts request timing,
// sweep words, FIFO contents and sticky flags from the sweep/timeout/period rules.
module tb_ci_sampler;

  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] periodCycles = '0;
  logic [31:0] controlWord = '0;
  logic        ciStart;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB;
  logic        ciDone = 1'b0;
  logic [31:0] ciResult = '0;
  logic        popReq = 1'b0;
  logic        sampleValid;
  logic [31:0] sampleData;
  logic [1:0]  sampleIndex;
  logic [3:0]  fifoCount;
  logic        busy, overflowErr, timeoutErr;
`ifdef CI_SAMPLER_TIMESTAMP_EN
  logic [31:0] sampleTimestamp;
`endif

  ci_sampler #(.CUSTOM_ID(8'h00), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .periodCycles(periodCycles),
    .controlWord(controlWord), .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA),
    .ciValueB(ciValueB), .ciDone(ciDone), .ciResult(ciResult), .popReq(popReq),
    .sampleValid(sampleValid), .sampleData(sampleData), .sampleIndex(sampleIndex),
    .fifoCount(fifoCount), .busy(busy), .overflowErr(overflowErr), .timeoutErr(timeoutErr)
`ifdef CI_SAMPLER_TIMESTAMP_EN
    , .sampleTimestamp(sampleTimestamp)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [1:0] idx; logic [31:0] res; } ent_t;

  int n_cmp = 0, n_err = 0, cyc = 0;
  ent_t q[$];
  bit   m_ovf, m_tmo, in_sweep, pend;
  int   next_start, idle_from, period_end, decide_at;
  int   pend_start, pend_idx, pend_lat, exp_idx;
  logic [31:0] exp_word;

  // Stimulus knobs
  int en_mode;      // 0 hold, 1 random toggle, 2 drop while index 1 outstanding
  int lat_mode;     // 0 prompt (latency 1), 1 random latency incl. silence
  int silent_idx;   // index that never answers, -1 for none
  int pop_mode;     // 0 none, 1 random, 2 only to make room for a push into a full FIFO
  int per_max;
  bit spur_en, prompt_res;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".ciStart"}, ciStart, 0);
    check_val({tag, ".ciN"}, ciN, 0);
    check_val({tag, ".ciValueA"}, ciValueA, 0);
    check_val({tag, ".ciValueB"}, ciValueB, 0);
    check_val({tag, ".sampleValid"}, sampleValid, 0);
    check_val({tag, ".sampleData"}, sampleData, 0);
    check_val({tag, ".sampleIndex"}, sampleIndex, 0);
    check_val({tag, ".fifoCount"}, fifoCount, 0);
    check_val({tag, ".busy"}, busy, 0);
    check_val({tag, ".overflowErr"}, overflowErr, 0);
    check_val({tag, ".timeoutErr"}, timeoutErr, 0);
  endtask

  function automatic int pick_lat(input int idx);
    int r;
    if (idx == silent_idx) return 0;
    if (lat_mode == 0) return 1;
    r = $urandom_range(9);
    if (r == 0) return 0;
    if (r < 7) return 1;
    return $urandom_range(TIMEOUT, 2);
  endfunction

  task automatic run_cycle(input bit rst_now);
    bit   exp_start, do_done;
    ent_t e;
    exp_start = (cyc == next_start);
    check_val("ciStart", ciStart, exp_start);
    check_val("busy", busy, in_sweep || exp_start);
    check_val("sampleValid", sampleValid, q.size() > 0);
    check_val("fifoCount", fifoCount, q.size());
    if (q.size() > 0) begin
      check_val("sampleData", sampleData, q[0].res);
      check_val("sampleIndex", sampleIndex, q[0].idx);
    end
    check_val("overflowErr", overflowErr, m_ovf);
    check_val("timeoutErr", timeoutErr, m_tmo);
    if (exp_start) begin
      check_val("ciValueA", ciValueA, exp_idx);
      check_val("ciValueB", ciValueB, exp_word);
      check_val("ciN", ciN, 0);
    end

    reset = rst_now;
    if (en_mode == 1 && $urandom_range(39) == 0) enable = ~enable;
    if (en_mode == 2 && pend && pend_idx == 1) enable = 1'b0;
    controlWord  = $urandom;
    periodCycles = 16'($urandom_range(per_max));
    do_done = pend && pend_lat != 0 && cyc == pend_start + pend_lat;
    if (!do_done && !pend && spur_en && $urandom_range(4) == 0) begin
      ciDone   = 1'b1;
      ciResult = 32'hDEAD;
    end else begin
      ciDone   = do_done;
      ciResult = (do_done && prompt_res) ? 32'h10 + 32'(pend_idx) : $urandom;
    end
    case (pop_mode)
      1:       popReq = $urandom_range(1) == 1;
      2:       popReq = (q.size() == DEPTH) && do_done;
      default: popReq = 1'b0;
    endcase

    if (rst_now) begin
      q.delete();
      m_ovf = 0; m_tmo = 0; pend = 0; in_sweep = 0;
      next_start = -1; period_end = -1; decide_at = -1;
      idle_from = cyc + 1; exp_idx = 0; exp_word = '0;
    end else begin
      if (idle_from >= 0 && cyc >= idle_from && enable) begin
        next_start = cyc + 1; exp_word = controlWord; exp_idx = 0; idle_from = -1;
      end
      if (period_end >= 0) begin
        if (!enable) begin
          idle_from = cyc + 1; next_start = -1; period_end = -1;
        end else if (cyc == period_end) begin
          exp_word = controlWord; exp_idx = 0; period_end = -1;
        end
      end
      if (cyc == decide_at) begin
        decide_at = -1; in_sweep = 0;
        if (enable) begin
          period_end = cyc + 1 + int'(periodCycles);
          next_start = cyc + 2 + int'(periodCycles);
        end else begin
          idle_from = cyc + 1;
        end
      end
      if (popReq && q.size() > 0) void'(q.pop_front());
      if (pend && (do_done || cyc == pend_start + TIMEOUT)) begin
        if (do_done) begin
          e.idx = 2'(pend_idx);
          e.res = ciResult;
          if (q.size() < DEPTH) q.push_back(e);
          else m_ovf = 1;
        end else begin
          m_tmo = 1;
        end
        pend = 0;
        if (pend_idx < 3) next_start = cyc + 2;
        else decide_at = cyc + 1;
      end
      if (exp_start) begin
        pend = 1; pend_start = cyc; pend_idx = exp_idx; exp_idx++;
        if (pend_idx == 0) in_sweep = 1;
        pend_lat = pick_lat(pend_idx);
        next_start = -1;
      end
    end
    tick();
  endtask

  task automatic set_knobs(input int em, input int lm, input int si, input int pm,
                           input int pmax, input bit spur, input bit prompt);
    en_mode = em; lat_mode = lm; silent_idx = si; pop_mode = pm;
    per_max = pmax; spur_en = spur; prompt_res = prompt;
  endtask

  initial begin
    m_ovf = 0; m_tmo = 0; in_sweep = 0; pend = 0;
    next_start = -1; period_end = -1; decide_at = -1; exp_idx = 0; exp_word = '0;
    pend_start = 0; pend_idx = 0; pend_lat = 0;
    set_knobs(0, 0, -1, 0, 0, 0, 1);
    repeat (2) tick();
    check_reset_outputs("reset_state");
    idle_from = cyc;

    // Prompt responder, no pops: first sweep fills four entries 0x10..0x13
    enable = 1'b1;
    repeat (14) run_cycle(0);
    check_val("first_sweep_count", fifoCount, 4);
    check_val("first_sweep_head_idx", sampleIndex, 0);
    check_val("first_sweep_head_data", sampleData, 32'h10);
    set_knobs(0, 0, -1, 1, 0, 0, 1);
    repeat (40) run_cycle(0);

    // Index 2 never answers
    set_knobs(0, 0, 2, 1, 3, 0, 1);
    repeat (80) run_cycle(0);
    check_val("silent_timeout_flag", timeoutErr, 1);

    // Overflow from empty over three sweeps
    set_knobs(0, 0, -1, 0, 0, 0, 1);
    run_cycle(1);
    repeat (45) run_cycle(0);
    check_val("ovf_count", fifoCount, 8);
    check_val("ovf_flag", overflowErr, 1);
    check_val("ovf_head_idx", sampleIndex, 0);
    check_val("ovf_head_data", sampleData, 32'h10);

    // Full FIFO with pops coinciding with pushes
    set_knobs(0, 1, -1, 2, 2, 0, 0);
    run_cycle(1);
    repeat (90) run_cycle(0);
    check_val("fullpop_count", fifoCount, 8);
    check_val("fullpop_no_ovf", overflowErr, 0);

    // Enable dropped while index 1 is outstanding
    set_knobs(2, 0, -1, 0, 0, 0, 1);
    enable = 1'b1;
    run_cycle(1);
    repeat (40) run_cycle(0);
    check_val("drop_idle_busy", busy, 0);
    check_val("drop_count", fifoCount, 4);

    // Spurious done while idle
    set_knobs(0, 0, -1, 0, 0, 1, 1);
    enable = 1'b0;
    repeat (12) run_cycle(0);

    // Randomized soak
    set_knobs(1, 1, -1, 1, 4, 1, 0);
    enable = 1'b1;
    run_cycle(1);
    repeat (1500) run_cycle(0);

    // Reset while waiting for a response
    set_knobs(0, 1, -1, 1, 2, 0, 0);
    enable = 1'b1;
    for (int i = 0; i < 60 && !(pend && cyc > pend_start); i++) run_cycle(0);
    check_val("reach_wait_done", (pend && cyc > pend_start), 1);
    enable = 1'b0;
    run_cycle(1);
    check_reset_outputs("mid_reset");
    repeat (6) run_cycle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
